// File: rtl/led_sequencer.sv
// Command-driven LED pattern player: shifts a pattern word onto light_on LSB-first
// at a prescaled step rate, with one queued command for gapless back-to-back playback.
module led_sequencer #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PAT_W   = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PAT_W-1:0] cmd_pattern,
    input  logic [CNT_W-1:0] cmd_repeat,
    input  logic             cmd_abort,
    output logic             light_on,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] act_pat;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] rep_cnt;
    logic [PRE_W-1:0] presc;
    logic             pend_full;
    logic [PAT_W-1:0] pend_pat;
    logic [CNT_W-1:0] pend_rep;

    logic             accept;
    logic             tick;
    logic             last_bit;
    logic             finish;
    logic [IDX_W-1:0] nxt_idx;

    // Slot is free whenever the pending register is empty, except while aborting.
    assign cmd_ready = !pend_full && !cmd_abort;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (presc == PRE_W'(CLK_DIV - 1));
    assign last_bit  = (bit_idx == IDX_W'(PAT_W - 1));
    assign finish    = (state == RUN) && tick && last_bit && (rep_cnt == '0);
    assign nxt_idx   = bit_idx + IDX_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            act_pat   <= '0;
            bit_idx   <= '0;
            rep_cnt   <= '0;
            presc     <= '0;
            pend_full <= 1'b0;
            pend_pat  <= '0;
            pend_rep  <= '0;
            light_on  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_abort) begin
                // Abort overrides completion and handshake on the same edge.
                state     <= IDLE;
                bit_idx   <= '0;
                rep_cnt   <= '0;
                presc     <= '0;
                pend_full <= 1'b0;
                light_on  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= RUN;
                            act_pat  <= cmd_pattern;
                            rep_cnt  <= cmd_repeat;
                            bit_idx  <= '0;
                            presc    <= '0;
                            light_on <= cmd_pattern[0];
                            busy     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!tick) begin
                            presc <= presc + PRE_W'(1);
                        end else begin
                            presc <= '0;
                            if (!last_bit) begin
                                bit_idx  <= nxt_idx;
                                light_on <= act_pat[nxt_idx];
                            end else if (rep_cnt != '0) begin
                                rep_cnt  <= rep_cnt - CNT_W'(1);
                                bit_idx  <= '0;
                                light_on <= act_pat[0];
                            end else begin
                                done    <= 1'b1;
                                bit_idx <= '0;
                                if (pend_full) begin
                                    act_pat   <= pend_pat;
                                    rep_cnt   <= pend_rep;
                                    light_on  <= pend_pat[0];
                                    pend_full <= 1'b0;
                                end else if (accept) begin
                                    // Command arriving on the finishing edge starts with no gap.
                                    act_pat  <= cmd_pattern;
                                    rep_cnt  <= cmd_repeat;
                                    light_on <= cmd_pattern[0];
                                end else begin
                                    state    <= IDLE;
                                    light_on <= 1'b0;
                                    busy     <= 1'b0;
                                end
                            end
                        end
                        if (accept && !finish) begin
                            pend_pat  <= cmd_pattern;
                            pend_rep  <= cmd_repeat;
                            pend_full <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
